// File: rtl/acq_search_ctrl_if.sv
// Control/status bundle between acquisition registers, correlator and acq_search_ctrl.
interface acq_search_ctrl_if #(
    parameter int PRN_PHS_WIDTH  = 11,
    parameter int CORR_ACC_WIDTH = 48
);
    // rx_start is a one-cycle request honoured only while idle; tx_done is a
    // one-cycle completion strobe. There is no backpressure in either direction.
    logic                      rx_start;
    logic                      rx_abort;
    logic [CORR_ACC_WIDTH-1:0] rx_thresh;
    logic [CORR_ACC_WIDTH-1:0] rx_corr_acc;
    logic                      tx_prn_sop;
    logic                      tx_prn_eop;
    logic [PRN_PHS_WIDTH-1:0]  tx_prn_phs;
    logic                      tx_busy;
    logic                      tx_done;
    logic                      tx_found;
    logic [CORR_ACC_WIDTH-1:0] tx_peak_pow;
    logic [PRN_PHS_WIDTH-1:0]  tx_peak_phs;
    logic [1:0]                dbg_state;

    modport master (
        output rx_start, rx_abort, rx_thresh, rx_corr_acc,
        input  tx_prn_sop, tx_prn_eop, tx_prn_phs, tx_busy, tx_done,
        input  tx_found, tx_peak_pow, tx_peak_phs, dbg_state
    );

    modport slave (
        input  rx_start, rx_abort, rx_thresh, rx_corr_acc,
        output tx_prn_sop, tx_prn_eop, tx_prn_phs, tx_busy, tx_done,
        output tx_found, tx_peak_pow, tx_peak_phs, dbg_state
    );
endinterface

// File: rtl/acq_search_ctrl.sv
// Code-phase search sequencer: sweeps phases, frames dwells, tracks peak power.
// Optional ACQ_EARLY_STOP_EN: finish on the first phase whose power exceeds the threshold.
module acq_search_ctrl #(
    parameter int PRN_LEN        = 2046,
    parameter int PHS_NUM        = 2046,
    parameter int PRN_PHS_WIDTH  = 11,
    parameter int CORR_ACC_WIDTH = 48
) (
    input  logic             rx_clk,
    input  logic             rx_rst,
    acq_search_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PRN_PHS_WIDTH-1:0] LAST_CHIP   = PRN_PHS_WIDTH'(PRN_LEN - 1);
    localparam logic [PRN_PHS_WIDTH-1:0] LAST_PHS    = PRN_PHS_WIDTH'(PHS_NUM - 1);
    localparam logic                     SINGLE_CHIP = (PRN_LEN == 1);
`ifdef ACQ_EARLY_STOP_EN
    localparam logic EARLY_STOP = 1'b1;
`else
    localparam logic EARLY_STOP = 1'b0;
`endif

    state_t                    state_q, state_d;
    logic [PRN_PHS_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PRN_PHS_WIDTH-1:0]  phs_q, phs_d;
    logic [PRN_PHS_WIDTH-1:0]  peak_phs_q, peak_phs_d;
    logic [CORR_ACC_WIDTH-1:0] peak_pow_q, peak_pow_d;
    logic [CORR_ACC_WIDTH-1:0] thresh_q, thresh_d;
    logic                      sop_q, sop_d;
    logic                      eop_q, eop_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      found_q, found_d;
    logic                      acc_gt_peak;
    logic                      acc_gt_thr;

    assign acc_gt_peak = (bus.rx_corr_acc > peak_pow_q);
    assign acc_gt_thr  = (bus.rx_corr_acc > thresh_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phs_d      = phs_q;
        peak_phs_d = peak_phs_q;
        peak_pow_d = peak_pow_q;
        thresh_d   = thresh_q;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        if (bus.rx_abort) begin
            // Abort wins over everything, including a same-cycle start; peak is held.
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            found_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_start) begin
                        state_d    = S_RUN;
                        thresh_d   = bus.rx_thresh;
                        cnt_d      = '0;
                        phs_d      = '0;
                        peak_pow_d = '0;
                        peak_phs_d = '0;
                        found_d    = 1'b0;
                        busy_d     = 1'b1;
                        sop_d      = 1'b1;
                        eop_d      = SINGLE_CHIP;
                    end
                end
                S_RUN: begin
                    if (cnt_q == LAST_CHIP) begin
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        eop_d = (cnt_d == LAST_CHIP);
                    end
                end
                S_EVAL: begin
                    // Strict compare: a tie keeps the earlier phase.
                    if (acc_gt_peak) begin
                        peak_pow_d = bus.rx_corr_acc;
                        peak_phs_d = phs_q;
                    end
                    if (EARLY_STOP && acc_gt_thr) begin
                        peak_pow_d = bus.rx_corr_acc;
                        peak_phs_d = phs_q;
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        found_d    = 1'b1;
                    end else if (phs_q == LAST_PHS) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        found_d = (peak_pow_d > thresh_q);
                    end else begin
                        state_d = S_RUN;
                        phs_d   = phs_q + 1'b1;
                        cnt_d   = '0;
                        sop_d   = 1'b1;
                        eop_d   = SINGLE_CHIP;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phs_q      <= '0;
            peak_phs_q <= '0;
            peak_pow_q <= '0;
            thresh_q   <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phs_q      <= phs_d;
            peak_phs_q <= peak_phs_d;
            peak_pow_q <= peak_pow_d;
            thresh_q   <= thresh_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
        end
    end

    assign bus.tx_prn_sop  = sop_q;
    assign bus.tx_prn_eop  = eop_q;
    assign bus.tx_prn_phs  = phs_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_found    = found_q;
    assign bus.tx_peak_pow = peak_pow_q;
    assign bus.tx_peak_phs = peak_phs_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_acq_search_ctrl.sv
// Randomised scoreboard bench for acq_search_ctrl (small PRN_LEN/PHS_NUM for speed).
module tb_acq_search_ctrl;
    localparam int L  = 8;
    localparam int N  = 4;
    localparam int PW = 11;
    localparam int AW = 48;
    localparam int EW = 64 + AW + PW + 1;

    logic        clk;
    logic        rx_rst;
    logic [63:0] cyc;
    int          n_checks;
    int          n_fail;

    logic [AW-1:0] pow_tab [N];
    logic [EW-1:0] exp_q [$];

    acq_search_ctrl_if #(.PRN_PHS_WIDTH(PW), .CORR_ACC_WIDTH(AW)) bus ();

    acq_search_ctrl #(
        .PRN_LEN(L), .PHS_NUM(N), .PRN_PHS_WIDTH(PW), .CORR_ACC_WIDTH(AW)
    ) dut (
        .rx_clk(clk),
        .rx_rst(rx_rst),
        .bus(bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 64'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Whole-sweep outcome from the power table: done cycle, peak, phase, found.
    function automatic logic [EW-1:0] model(input logic [AW-1:0] th, input logic [63:0] t0);
        logic [AW-1:0] best;
        logic [PW-1:0] bphs;
        logic          found;
        logic          stopped;
        int            k;
        best    = '0;
        bphs    = '0;
        found   = 1'b0;
        stopped = 1'b0;
        k       = N;
        for (int i = 0; i < N; i++) begin
            if (!stopped) begin
`ifdef ACQ_EARLY_STOP_EN
                if (pow_tab[i] > th) begin
                    best    = pow_tab[i];
                    bphs    = PW'(i);
                    found   = 1'b1;
                    stopped = 1'b1;
                    k       = i + 1;
                end
`endif
                if (!stopped && pow_tab[i] > best) begin
                    best = pow_tab[i];
                    bphs = PW'(i);
                end
            end
        end
        if (!stopped) found = (best > th);
        return {t0 + 64'd1 + 64'(k * (L + 1)), best, bphs, found};
    endfunction

    // ---------------- drivers ----------------
    // Power seen by the DUT follows the phase hypothesis it is currently dwelling on.
    initial begin
        bus.rx_corr_acc = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rx_corr_acc = (bus.tx_prn_phs < PW'(N)) ? pow_tab[bus.tx_prn_phs] : '0;
        end
    end

    task automatic set_pows(input logic [AW-1:0] p0, p1, p2, p3);
        pow_tab[0] = p0;
        pow_tab[1] = p1;
        pow_tab[2] = p2;
        pow_tab[3] = p3;
    endtask

    task automatic run_sweep(input logic [AW-1:0] th, input bit mid_start);
        @(negedge clk);
        bus.rx_thresh = th;
        bus.rx_start  = 1'b1;
        exp_q.push_back(model(th, cyc));
        @(negedge clk);
        bus.rx_start  = 1'b0;
        bus.rx_thresh = {16'($urandom), 32'($urandom)};
        if (mid_start) begin
            repeat (3) @(negedge clk);
            bus.rx_start = 1'b1;
            @(negedge clk);
            bus.rx_start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.tx_done) return;
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_busy;
        logic          in_dwell;
        logic [63:0]   sop_cyc;
        logic [PW-1:0] sop_phs;
        logic [PW-1:0] nxt_phs;
        logic [EW-1:0] e;
        prev_busy = 1'b0;
        in_dwell  = 1'b0;
        sop_cyc   = '0;
        sop_phs   = '0;
        nxt_phs   = '0;
        forever begin
            @(negedge clk);
            if (rx_rst) begin
                prev_busy = 1'b0;
                in_dwell  = 1'b0;
                continue;
            end
            if (bus.tx_busy && !prev_busy) begin
                nxt_phs  = '0;
                in_dwell = 1'b0;
                chk("sop_at_busy_rise", 64'(bus.tx_prn_sop), 64'd1);
            end
            prev_busy = bus.tx_busy;
            if (bus.tx_prn_sop) begin
                chk("sop_phase", 64'(bus.tx_prn_phs), 64'(nxt_phs));
                chk("sop_busy", 64'(bus.tx_busy), 64'd1);
                nxt_phs  = nxt_phs + 1'b1;
                sop_cyc  = cyc;
                sop_phs  = bus.tx_prn_phs;
                in_dwell = 1'b1;
            end
            if (bus.tx_prn_eop) begin
                chk("eop_in_dwell", 64'(in_dwell), 64'd1);
                chk("sop_eop_spacing", cyc - sop_cyc, 64'(L - 1));
                chk("phs_stable", 64'(bus.tx_prn_phs), 64'(sop_phs));
                in_dwell = 1'b0;
            end
            if (bus.tx_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e[EW-1 -: 64]);
                    chk("peak_pow", 64'(bus.tx_peak_pow), 64'(e[PW+1 +: AW]));
                    chk("peak_phs", 64'(bus.tx_peak_phs), 64'(e[1 +: PW]));
                    chk("found", 64'(bus.tx_found), 64'(e[0]));
                    chk("busy_at_done", 64'(bus.tx_busy), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        logic [AW-1:0] th;
        bit            found_phs2;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = '0;
        rx_rst        = 1'b1;
        bus.rx_start  = 1'b0;
        bus.rx_abort  = 1'b0;
        bus.rx_thresh = '0;
        set_pows(48'd0, 48'd0, 48'd0, 48'd0);
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(bus.dbg_state), 64'd0);
        chk("rst_outputs", 64'({bus.tx_prn_sop, bus.tx_prn_eop, bus.tx_busy,
            bus.tx_done, bus.tx_found, bus.tx_prn_phs, bus.tx_peak_phs}), 64'd0);
        chk("rst_peak_pow", 64'(bus.tx_peak_pow), 64'd0);
        rx_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: global max, equal-threshold non-detection, tie, early-stop table.
        set_pows(48'd10, 48'd20, 48'd30, 48'd5);
        run_sweep(48'd25, 1'b1);
        wait_done();
        run_sweep(48'd30, 1'b0);
        wait_done();
        set_pows(48'd40, 48'd40, 48'd10, 48'd10);
        run_sweep(48'd100, 1'b0);
        wait_done();
        set_pows(48'd10, 48'd50, 48'd60, 48'd5);
        run_sweep(48'd25, 1'b0);
        wait_done();

        // Abort in the middle of phase 2's dwell.
        set_pows(48'd10, 48'd20, 48'd30, 48'd5);
        repeat (2) @(negedge clk);
        run_sweep({AW{1'b1}}, 1'b0);
        found_phs2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.tx_prn_phs == PW'(2)) begin
                found_phs2 = 1'b1;
                break;
            end
        end
        chk("reach_phase2", 64'(found_phs2), 64'd1);
        repeat (3) @(negedge clk);
        bus.rx_abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.rx_abort = 1'b0;
        chk("abort_busy", 64'(bus.tx_busy), 64'd0);
        chk("abort_state", 64'(bus.dbg_state), 64'd0);
        chk("abort_found", 64'(bus.tx_found), 64'd0);
        chk("abort_peak_pow", 64'(bus.tx_peak_pow), 64'd20);
        chk("abort_peak_phs", 64'(bus.tx_peak_phs), 64'd1);
        repeat (40) @(negedge clk);
        bus.rx_start = 1'b1;
        bus.rx_abort = 1'b1;
        @(negedge clk);
        bus.rx_start = 1'b0;
        bus.rx_abort = 1'b0;
        chk("abort_beats_start", 64'(bus.tx_busy), 64'd0);
        chk("abort_start_hold", 64'(bus.tx_peak_pow), 64'd20);

        // Asynchronous reset in the middle of a dwell.
        run_sweep(48'd25, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rx_rst = 1'b1;
        #1;
        chk("async_rst_outputs", 64'({bus.tx_prn_sop, bus.tx_prn_eop, bus.tx_busy,
            bus.tx_done, bus.tx_found, bus.tx_prn_phs, bus.tx_peak_phs}), 64'd0);
        chk("async_rst_peak_pow", 64'(bus.tx_peak_pow), 64'd0);
        chk("async_rst_state", 64'(bus.dbg_state), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rx_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Random sweeps, mixing back-to-back and spaced starts.
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < N; i++) begin
                pow_tab[i] = ($urandom_range(0, 3) == 0) ? {16'($urandom), 32'($urandom)}
                                                         : 48'($urandom_range(0, 40));
            end
            th = ($urandom_range(0, 3) == 0) ? {16'($urandom), 32'($urandom)}
                                             : 48'($urandom_range(0, 45));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
            run_sweep(th, $urandom_range(0, 3) == 0);
            wait_done();
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
